// File: rtl/pll_clock_monitor_if.sv
// rtl/pll_clock_monitor_if.sv - control/status bundle between software-side logic and the PLL clock monitor
interface pll_clock_monitor_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic [CNT_W-1:0] min_count;
  logic [CNT_W-1:0] max_count;
  logic             req_pll_sel;
  logic [2:0]       sel_in;
  logic [2:0]       sel2_in;
  logic             fault_clr;
  logic             ext_clk_sel;
  logic [2:0]       sel;
  logic [2:0]       sel2;
  logic             pll_locked;
  logic [CNT_W-1:0] meas_count;
  logic             meas_valid;
  logic             fault;

  modport master (
    output enable, min_count, max_count, req_pll_sel, sel_in, sel2_in, fault_clr,
    input  ext_clk_sel, sel, sel2, pll_locked, meas_count, meas_valid, fault
  );

  modport slave (
    input  enable, min_count, max_count, req_pll_sel, sel_in, sel2_in, fault_clr,
    output ext_clk_sel, sel, sel2, pll_locked, meas_count, meas_valid, fault
  );
endinterface

// File: rtl/pll_clock_monitor.sv
// rtl/pll_clock_monitor.sv - PLL frequency qualification, lock hysteresis and clock-mux select sequencing
module pll_clock_monitor #(
  parameter int         WIN_EXT    = 16,
  parameter int         CNT_W      = 16,
  parameter int         LOCK_COUNT = 3,
  parameter logic [2:0] SEL_RST    = 3'b001
) (
  input  logic               pll_clk,
  input  logic               resetb,
  input  logic               ext_clk,
  pll_clock_monitor_if.slave mon
);

  localparam int EW = $clog2(WIN_EXT + 1);
  localparam int SW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam logic [EW-1:0]    EDGE_ONE   = EW'(1);
  localparam logic [EW-1:0]    EDGE_LAST  = EW'(WIN_EXT);
  localparam logic [SW-1:0]    STREAK_ONE = SW'(1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(LOCK_COUNT);
  localparam logic [CNT_W:0]   WIDE_ONE   = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             ext_s1, ext_s2, ext_hist, ext_rise;
  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic [EW-1:0]    edge_cnt;
  logic [SW-1:0]    streak, streak_next;
  logic [CNT_W:0]   cnt_inc, min_wide, max_wide, capture, cap_q;
  logic             counting, timeout, win_end, good;
  logic             meas_valid_q, pll_locked_q, locked_next;
  logic             ext_clk_sel_q, fault_q, fault_set;
  logic [CNT_W-1:0] meas_count_q;
  logic [2:0]       sel_q, sel2_q;

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
      ext_hist <= 1'b0;
    end else begin
      ext_s1   <= ext_clk;
      ext_s2   <= ext_s1;
      ext_hist <= ext_s2;
    end
  end

  assign ext_rise = ext_s2 & ~ext_hist;

  // One extra bit so counter+1 and max_count+1 never wrap in the compares.
  assign min_wide = {1'b0, mon.min_count};
  assign max_wide = {1'b0, mon.max_count};
  assign cnt_inc  = {1'b0, counter} + WIDE_ONE;
  assign counting = mon.enable && (state == ST_ARM || state == ST_MEAS);
  assign timeout  = counting && (cnt_inc > max_wide);
  assign win_end  = mon.enable && (state == ST_MEAS) && ext_rise &&
                    (edge_cnt + EDGE_ONE == EDGE_LAST) && !timeout;
  assign capture  = timeout ? (max_wide + WIDE_ONE) : cnt_inc;

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      state    <= ST_IDLE;
      counter  <= '0;
      edge_cnt <= '0;
    end else if (!mon.enable) begin
      state    <= ST_IDLE;
      counter  <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          counter  <= '0;
          edge_cnt <= '0;
          state    <= ST_ARM;
        end
        ST_ARM: begin
          if (timeout) begin
            counter <= '0;
          end else if (ext_rise) begin
            counter  <= '0;
            edge_cnt <= '0;
            state    <= ST_MEAS;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        ST_MEAS: begin
          if (timeout) begin
            counter  <= '0;
            edge_cnt <= '0;
            state    <= ST_ARM;
          end else if (win_end) begin
            // Boundary edge closes this window and opens the next one.
            counter  <= '0;
            edge_cnt <= '0;
          end else begin
            if (ext_rise) edge_cnt <= edge_cnt + EDGE_ONE;
            if (counter != '1) counter <= counter + CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      meas_valid_q <= 1'b0;
      meas_count_q <= '0;
      cap_q        <= '0;
    end else begin
      meas_valid_q <= win_end | timeout;
      if (win_end | timeout) begin
        cap_q        <= capture;
        meas_count_q <= capture[CNT_W] ? '1 : capture[CNT_W-1:0];
      end
    end
  end

  // Range check uses the full-width capture so an overflowed window is never good.
  assign good = (min_wide <= cap_q) && (cap_q <= max_wide);

  always_comb begin
    streak_next = streak;
    locked_next = pll_locked_q;
    if (!mon.enable || state == ST_IDLE) begin
      streak_next = '0;
      locked_next = 1'b0;
    end else if (meas_valid_q) begin
      if (good) begin
        if (streak != STREAK_MAX) streak_next = streak + STREAK_ONE;
        if (streak_next == STREAK_MAX) locked_next = 1'b1;
      end else begin
        streak_next = '0;
        locked_next = 1'b0;
      end
    end
  end

  assign fault_set = mon.enable & meas_valid_q & pll_locked_q & ~good;

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      streak        <= '0;
      pll_locked_q  <= 1'b0;
      ext_clk_sel_q <= 1'b1;
      fault_q       <= 1'b0;
      sel_q         <= SEL_RST;
      sel2_q        <= SEL_RST;
    end else begin
      streak        <= streak_next;
      pll_locked_q  <= locked_next;
      ext_clk_sel_q <= ~(mon.req_pll_sel & locked_next);
      fault_q       <= fault_set | (fault_q & ~mon.fault_clr);
      // Dividers only follow software while the mux is still on ext_clk.
      if (ext_clk_sel_q) begin
        sel_q  <= mon.sel_in;
        sel2_q <= mon.sel2_in;
      end
    end
  end

  assign mon.ext_clk_sel = ext_clk_sel_q;
  assign mon.sel         = sel_q;
  assign mon.sel2        = sel2_q;
  assign mon.pll_locked  = pll_locked_q;
  assign mon.meas_count  = meas_count_q;
  assign mon.meas_valid  = meas_valid_q;
  assign mon.fault       = fault_q;

endmodule
